// File: rtl/chip8_pkg.sv
// chip8_pkg: shared types and constants for the CHIP-8 draw engine.
//   state_t           engine FSM state
//   SPR_*             sprite shape constants (8-wide rows, 16x16 SUPER-CHIP)
//   ROW_CNT_W         width of row counters (holds 0..16)
//   lores_w/lores_h   logical size in lo-res mode from physical size
package chip8_pkg;
  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CLEAR    = 3'd1,
    S_FETCH_HI = 3'd2,
    S_FETCH_LO = 3'd3,
    S_APPLY    = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  localparam int SPR_NARROW_BITS = 8;
  localparam int SPR_WIDE_BITS   = 16;
  localparam int SPR_WIDE_ROWS   = 16;
  localparam int ROW_CNT_W       = 5;

  function automatic int lores_w(input int w);
    return w / 2;
  endfunction

  function automatic int lores_h(input int h);
    return h / 2;
  endfunction
endpackage

// File: rtl/chip8_row_merge.sv
// chip8_row_merge: expands one fetched sprite row into a WIDTH-bit physical
// row mask, XORs it into the current framebuffer row and flags collisions.
//   hires    1 = pixel per column, 0 = each logical pixel covers 2 columns
//   wide     1 = 16-bit row {hi,lo}, 0 = 8-bit row in bits[15:8]
//   x0       logical start column (already reduced modulo logical width)
//   bits     sprite row, MSB is leftmost pixel
//   cur_row  current physical framebuffer row
//   new_row  cur_row ^ mask
//   collide  some lit pixel was turned off
// Macro CHIP8_DRAW_WRAP_EN: columns wrap modulo logical width instead of
// being clipped.
module chip8_row_merge
  import chip8_pkg::*;
#(
  parameter int WIDTH = 128,
  localparam int CW = $clog2(WIDTH)
) (
  input  logic             hires,
  input  logic             wide,
  input  logic [CW-1:0]    x0,
  input  logic [15:0]      bits,
  input  logic [WIDTH-1:0] cur_row,
  output logic [WIDTH-1:0] new_row,
  output logic             collide
);
  localparam logic [CW:0] LW_HI = (CW+1)'(WIDTH);
  localparam logic [CW:0] LW_LO = (CW+1)'(lores_w(WIDTH));

  logic [WIDTH-1:0] mask;
  logic [15:0]      spr, sh;
  logic [CW:0]      lw, lx;
  logic [CW-1:0]    lxw;
  logic             keep;

  always_comb begin
    mask = '0;
    lw   = hires ? LW_HI : LW_LO;
    // left-align narrow rows so bit 15 is always the first pixel
    spr  = wide ? bits : {bits[15:8], 8'h00};
    sh   = '0;
    lx   = '0;
    lxw  = '0;
    keep = 1'b0;
    for (int c = 0; c < SPR_WIDE_BITS; c++) begin
      sh = spr << c;
      lx = (CW+1)'(x0) + (CW+1)'(c);
`ifdef CHIP8_DRAW_WRAP_EN
      keep = sh[15];
`else
      keep = sh[15] && (lx < lw);
`endif
      lxw = CW'(lx & (lw - 1'b1));
      if (keep) begin
        if (hires) begin
          mask[lxw] = 1'b1;
        end else begin
          mask[{lxw[CW-2:0], 1'b0}] = 1'b1;
          mask[{lxw[CW-2:0], 1'b1}] = 1'b1;
        end
      end
    end
  end

  assign new_row = cur_row ^ mask;
  assign collide = |(cur_row & mask);
endmodule

// File: rtl/chip8_draw_engine.sv
// chip8_draw_engine: multi-cycle DXYN / 00E0 engine over an internal
// WIDTH x HEIGHT framebuffer; sprite bytes fetched via mem_req/mem_valid.
//   clk, reset        clock, synchronous active-high reset
//   start, clear      issue draw / clear (accepted only when idle; clear wins)
//   hires, x, y, n    mode and DXYN operands, latched at accept
//   i_reg             sprite base address
//   mem_req/mem_addr  read request, address held until mem_valid
//   mem_data/valid    read return
//   busy, done        busy in every non-idle state, one-cycle done pulse
//   collision         VF result, held from done until next accept
//   display           framebuffer, bit row*WIDTH+col
// Macro CHIP8_DRAW_WRAP_EN: sprites wrap at the screen edges (rows and
// columns) instead of being clipped.
module chip8_draw_engine
  import chip8_pkg::*;
#(
  parameter int WIDTH  = 128,
  parameter int HEIGHT = 64,
  parameter int AW     = 12
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    clear,
  input  logic                    hires,
  input  logic [7:0]              x,
  input  logic [7:0]              y,
  input  logic [3:0]              n,
  input  logic [AW-1:0]           i_reg,
  output logic                    mem_req,
  output logic [AW-1:0]           mem_addr,
  input  logic [7:0]              mem_data,
  input  logic                    mem_valid,
  output logic                    busy,
  output logic                    done,
  output logic                    collision,
  output logic [WIDTH*HEIGHT-1:0] display
);
  localparam int CW = $clog2(WIDTH);
  localparam int RW = $clog2(HEIGHT);
  localparam int KW = RW - 1;
  localparam int YS = RW + ROW_CNT_W;
  localparam logic [CW:0] LW_HI = (CW+1)'(WIDTH);
  localparam logic [CW:0] LW_LO = (CW+1)'(lores_w(WIDTH));
  localparam logic [RW:0] LH_HI = (RW+1)'(HEIGHT);
  localparam logic [RW:0] LH_LO = (RW+1)'(lores_h(HEIGHT));

  state_t state, state_nx;

  logic [CW-1:0]          x0_r;
  logic [RW-1:0]          y0_r;
  logic                   hires_r, wide_r, coll_r;
  logic [AW-1:0]          ibase;
  logic [ROW_CNT_W-1:0]   nrows, rcnt;
  logic [7:0]             hi_byte, lo_byte;
  logic [KW-1:0]          clr_cnt;

  // ---- operands reduced at accept time
  logic [CW:0]            lw_in;
  logic [RW:0]            lh_in;
  logic [CW-1:0]          x0_in;
  logic [RW-1:0]          y0_in;
  logic [ROW_CNT_W-1:0]   rows_in, nrows_in;

  always_comb begin
    lw_in   = hires ? LW_HI : LW_LO;
    lh_in   = hires ? LH_HI : LH_LO;
    x0_in   = CW'(x) & CW'(lw_in - 1'b1);
    y0_in   = RW'(y) & RW'(lh_in - 1'b1);
    rows_in = (n != 4'd0) ? {1'b0, n}
            : (hires ? ROW_CNT_W'(SPR_WIDE_ROWS) : '0);
  end

`ifdef CHIP8_DRAW_WRAP_EN
  assign nrows_in = rows_in;
`else
  // rows below the bottom edge are never fetched
  logic [RW:0] avail;
  assign avail    = lh_in - {1'b0, y0_in};
  assign nrows_in = (YS'(avail) < YS'(rows_in)) ? ROW_CNT_W'(avail) : rows_in;
`endif

  // ---- current physical row(s) for the row being applied
  logic [RW:0]            lh_r;
  logic [YS-1:0]          ysum;
  logic [RW-1:0]          ly;
  logic [1:0][RW-1:0]     prow;
  logic [1:0][WIDTH-1:0]  cur_row, new_row;
  logic [1:0]             coll_l;

  always_comb begin
    lh_r    = hires_r ? LH_HI : LH_LO;
    ysum    = YS'(y0_r) + YS'(rcnt);
    ly      = RW'(ysum & YS'(lh_r - 1'b1));
    prow[0] = hires_r ? ly : {ly[RW-2:0], 1'b0};
    prow[1] = {prow[0][RW-1:1], 1'b1};
  end

  // lane 1 is the second physical row of a lo-res pixel; unused in hi-res
  generate
    for (genvar l = 0; l < 2; l++) begin : g_lane
      assign cur_row[l] = display[{prow[l], {CW{1'b0}}} +: WIDTH];
      chip8_row_merge #(.WIDTH(WIDTH)) u_merge (
        .hires   (hires_r),
        .wide    (wide_r),
        .x0      (x0_r),
        .bits    ({hi_byte, lo_byte}),
        .cur_row (cur_row[l]),
        .new_row (new_row[l]),
        .collide (coll_l[l])
      );
    end
  endgenerate

  // ---- FSM: state register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  // ---- FSM: next state
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (clear)      state_nx = S_CLEAR;
        else if (start) state_nx = (nrows_in == '0) ? S_DONE : S_FETCH_HI;
      end
      S_CLEAR:    if (clr_cnt == '1) state_nx = S_DONE;
      S_FETCH_HI: if (mem_valid) state_nx = wide_r ? S_FETCH_LO : S_APPLY;
      S_FETCH_LO: if (mem_valid) state_nx = S_APPLY;
      S_APPLY:    state_nx = (rcnt == nrows - 5'd1) ? S_DONE : S_FETCH_HI;
      S_DONE:     state_nx = S_IDLE;
      default:    state_nx = S_IDLE;
    endcase
  end

  // ---- FSM: outputs
  always_comb begin
    mem_req  = 1'b0;
    mem_addr = '0;
    busy     = (state != S_IDLE);
    done     = (state == S_DONE);
    case (state)
      S_FETCH_HI: begin
        mem_req  = 1'b1;
        mem_addr = ibase + (wide_r ? AW'({rcnt, 1'b0}) : AW'(rcnt));
      end
      S_FETCH_LO: begin
        mem_req  = 1'b1;
        mem_addr = ibase + AW'({rcnt, 1'b1});
      end
      default: ;
    endcase
  end

  assign collision = coll_r;

  // ---- datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      display <= '0;
      x0_r    <= '0;
      y0_r    <= '0;
      hires_r <= 1'b0;
      wide_r  <= 1'b0;
      coll_r  <= 1'b0;
      ibase   <= '0;
      nrows   <= '0;
      rcnt    <= '0;
      hi_byte <= '0;
      lo_byte <= '0;
      clr_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (clear) begin
            coll_r  <= 1'b0;
            clr_cnt <= '0;
          end else if (start) begin
            x0_r    <= x0_in;
            y0_r    <= y0_in;
            hires_r <= hires;
            wide_r  <= hires && (n == 4'd0);
            ibase   <= i_reg;
            nrows   <= nrows_in;
            rcnt    <= '0;
            coll_r  <= 1'b0;
          end
        end
        S_CLEAR: begin
          display[{clr_cnt, 1'b0, {CW{1'b0}}} +: 2*WIDTH] <= '0;
          clr_cnt <= clr_cnt + 1'b1;
        end
        S_FETCH_HI: if (mem_valid) hi_byte <= mem_data;
        S_FETCH_LO: if (mem_valid) lo_byte <= mem_data;
        S_APPLY: begin
          display[{prow[0], {CW{1'b0}}} +: WIDTH] <= new_row[0];
          if (!hires_r) display[{prow[1], {CW{1'b0}}} +: WIDTH] <= new_row[1];
          coll_r <= coll_r | coll_l[0] | (!hires_r & coll_l[1]);
          rcnt   <= rcnt + 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule
